// File: rtl/dma_zx_if.sv
// Bus bundle for dma_zx: Z80 register window, ZX DMA strobes and the NGS memory port.
// master = the DMA block, slave = the environment driving the Z80 side and serving memory.
interface dma_zx_if;
    logic [7:0]  dma_din_modules;
    logic        dma_select_zx;
    logic        dma_wrstb;
    logic [1:0]  dma_regsel;
    logic [7:0]  dma_dout_zx;
    logic        zx_req;
    logic        zx_rnw;
    logic [7:0]  zx_wdata;
    logic [7:0]  zx_rdata;
    logic        mem_req;
    logic        mem_rnw;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;
    logic        mem_ack;

    modport master (
        input  dma_din_modules, dma_select_zx, dma_wrstb, dma_regsel,
        input  zx_req, zx_rnw, zx_wdata, mem_rd, mem_ack,
        output dma_dout_zx, zx_rdata, mem_req, mem_rnw, mem_addr, mem_wd
    );

    modport slave (
        output dma_din_modules, dma_select_zx, dma_wrstb, dma_regsel,
        output zx_req, zx_rnw, zx_wdata, mem_rd, mem_ack,
        input  dma_dout_zx, zx_rdata, mem_req, mem_rnw, mem_addr, mem_wd
    );
endinterface

// File: rtl/dma_zx.sv
// ZX-side DMA: 21-bit auto-incrementing address, ZX->GS write FIFO, one-byte GS->ZX prefetch.
// Define DMA_ZX_WRAP64K_EN to keep address increments inside the current 64K page.
module dma_zx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     cpu_clock,
    input  logic     rst,
    dma_zx_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t      r_state, w_state_nxt;
    logic [20:0] r_addr, w_addr_inc;
    logic        r_en, r_dir, r_ovr, r_rbuf_valid;
    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [7:0]  r_zx_rdata, r_mem_wd;
    logic        r_mem_req, r_mem_rnw;
    logic [20:0] r_mem_addr;

    logic        w_reg_wr, w_cst_wr, w_addr_wr;
    logic        w_zx_wr, w_zx_rd, w_push, w_drop;
    logic        w_pop, w_issue_rd, w_done, w_rd_take;
    logic        w_fifo_empty, w_fifo_full, w_busy;
    logic [7:0]  w_dout;

    assign w_reg_wr  = bus.dma_wrstb && bus.dma_select_zx;
    assign w_cst_wr  = w_reg_wr && (bus.dma_regsel == 2'd3);
    assign w_addr_wr = w_reg_wr && (bus.dma_regsel != 2'd3) && !r_en;

    assign w_zx_wr = bus.zx_req && !bus.zx_rnw && r_en && !r_dir;
    assign w_zx_rd = bus.zx_req && bus.zx_rnw && r_en && r_dir;

    assign w_fifo_empty = (r_wptr == r_rptr);
    assign w_fifo_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push       = w_zx_wr && (!w_fifo_full || w_pop);
    assign w_drop       = w_zx_wr && w_fifo_full && !w_pop;
    assign w_busy       = (r_state != IDLE);

    // read data is only kept if the block is still enabled when the ack lands
    assign w_rd_take = w_done && (r_state == RD) && r_en;

`ifdef DMA_ZX_WRAP64K_EN
    assign w_addr_inc = {r_addr[20:16], r_addr[15:0] + 16'd1};
`else
    assign w_addr_inc = r_addr + 21'd1;
`endif

    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_issue_rd  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_en && !w_cst_wr) begin
                    if (!r_dir && !w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = WR;
                    end else if (r_dir && !r_rbuf_valid) begin
                        w_issue_rd  = 1'b1;
                        w_state_nxt = RD;
                    end
                end
            end
            WR, RD: begin
                if (bus.mem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock) begin
        if (w_push) r_fifo[r_wptr[AW-1:0]] <= bus.zx_wdata;
    end

    always_ff @(posedge cpu_clock or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_en         <= 1'b0;
            r_dir        <= 1'b0;
            r_ovr        <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_rbuf_valid <= 1'b0;
            r_zx_rdata   <= '0;
            r_mem_req    <= 1'b0;
            r_mem_rnw    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
        end else begin
            if (w_addr_wr) begin
                case (bus.dma_regsel)
                    2'd0:    r_addr[20:16] <= bus.dma_din_modules[4:0];
                    2'd1:    r_addr[15:8]  <= bus.dma_din_modules;
                    default: r_addr[7:0]   <= bus.dma_din_modules;
                endcase
            end else if (w_done) begin
                r_addr <= w_addr_inc;
            end

            if (w_cst_wr) begin
                r_en  <= bus.dma_din_modules[7];
                r_dir <= bus.dma_din_modules[0];
            end

            if (w_drop || (w_zx_rd && !r_rbuf_valid)) r_ovr <= 1'b1;
            else if (w_cst_wr && bus.dma_din_modules[6]) r_ovr <= 1'b0;

            if (w_cst_wr) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
                if (w_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
            end

            if (w_cst_wr)                     r_rbuf_valid <= 1'b0;
            else if (w_rd_take)               r_rbuf_valid <= 1'b1;
            else if (w_zx_rd && r_rbuf_valid) r_rbuf_valid <= 1'b0;

            if (w_rd_take) r_zx_rdata <= bus.mem_rd;

            if (w_pop) begin
                r_mem_req  <= 1'b1;
                r_mem_rnw  <= 1'b0;
                r_mem_addr <= r_addr;
                r_mem_wd   <= r_fifo[r_rptr[AW-1:0]];
            end else if (w_issue_rd) begin
                r_mem_req  <= 1'b1;
                r_mem_rnw  <= 1'b1;
                r_mem_addr <= r_addr;
            end else if (w_done) begin
                r_mem_req  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_dout = 8'h00;
        if (bus.dma_select_zx) begin
            case (bus.dma_regsel)
                2'd0:    w_dout = {3'b000, r_addr[20:16]};
                2'd1:    w_dout = r_addr[15:8];
                2'd2:    w_dout = r_addr[7:0];
                default: w_dout = {r_en, r_ovr, w_busy, w_fifo_empty, w_fifo_full, 2'b00, r_dir};
            endcase
        end
    end

    assign bus.dma_dout_zx = w_dout;
    assign bus.zx_rdata    = r_zx_rdata;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_rnw     = r_mem_rnw;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wd      = r_mem_wd;
endmodule

// File: tb/tb_dma_zx.sv
// Bench for dma_zx: expected memory transactions are queued as ZX stimulus is driven and
// checked by a memory responder when the DMA issues each request.
module tb_dma_zx;
    logic cpu_clock = 1'b0;
    logic rst       = 1'b1;

    dma_zx_if bus();

    dma_zx #(.FIFO_DEPTH(4)) dut (
        .cpu_clock (cpu_clock),
        .rst       (rst),
        .bus       (bus.master)
    );

    always #5 cpu_clock = ~cpu_clock;

    typedef struct {
        logic        rnw;
        logic [20:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
    } xfer_t;

    xfer_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    tb_nreq  = 0;
    int    tb_ack_dly = 1;
    int    tb_last_hold = 0;
    bit    tb_hold = 1'b0;
    bit    tb_in_xfer = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_x(input logic rnw, input logic [20:0] a, input logic [7:0] wd,
                            input logic [7:0] rd);
        xfer_t e;
        e.rnw = rnw; e.addr = a; e.wd = wd; e.rd = rd;
        sb_q.push_back(e);
    endtask

    task automatic reg_wr(input logic [1:0] sel, input logic [7:0] d);
        @(negedge cpu_clock);
        bus.dma_regsel      = sel;
        bus.dma_din_modules = d;
        bus.dma_wrstb       = 1'b1;
        @(negedge cpu_clock);
        bus.dma_wrstb       = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] sel, output logic [7:0] d);
        @(negedge cpu_clock);
        bus.dma_regsel = sel;
        #1 d = bus.dma_dout_zx;
    endtask

    task automatic zx_write(input logic [7:0] b);
        @(negedge cpu_clock);
        bus.zx_req   = 1'b1;
        bus.zx_rnw   = 1'b0;
        bus.zx_wdata = b;
        @(negedge cpu_clock);
        bus.zx_req   = 1'b0;
    endtask

    task automatic zx_read();
        @(negedge cpu_clock);
        bus.zx_req = 1'b1;
        bus.zx_rnw = 1'b1;
        @(negedge cpu_clock);
        bus.zx_req = 1'b0;
        bus.zx_rnw = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || tb_in_xfer) && n < 2000) begin
            @(negedge cpu_clock);
            n++;
        end
        chk({tag, "_done"}, 32'(n < 2000), 1);
        repeat (2) @(negedge cpu_clock);
    endtask

    // memory responder: compare each new request with the scoreboard head, then ack
    initial begin
        xfer_t e;
        int    cnt;
        bit    stable;
        bus.mem_ack = 1'b0;
        bus.mem_rd  = 8'h00;
        forever begin
            @(negedge cpu_clock);
            if (bus.mem_req === 1'b1) begin
                tb_in_xfer = 1'b1;
                tb_nreq++;
                if (sb_q.size() == 0) begin
                    chk("unexp_req", 1, 0);
                    e = '{1'b0, 21'h0, 8'h00, 8'h00};
                end else begin
                    e = sb_q.pop_front();
                    chk("mem_rnw", 32'(bus.mem_rnw), 32'(e.rnw));
                    chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    if (!e.rnw) chk("mem_wd", 32'(bus.mem_wd), 32'(e.wd));
                end
                cnt    = 1;
                stable = 1'b1;
                while (tb_hold || cnt < tb_ack_dly) begin
                    @(negedge cpu_clock);
                    if (bus.mem_req === 1'b1) cnt++;
                    if (bus.mem_addr !== e.addr || bus.mem_rnw !== e.rnw ||
                        (!e.rnw && bus.mem_wd !== e.wd)) stable = 1'b0;
                end
                tb_last_hold = cnt;
                chk("req_stable", 32'(stable), 1);
                bus.mem_rd  = e.rd;
                bus.mem_ack = 1'b1;
                @(negedge cpu_clock);
                bus.mem_ack = 1'b0;
                chk("req_drop", 32'(bus.mem_req), 0);
                tb_in_xfer = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench stalled");
    end

    initial begin
        logic [7:0] d;
        int         nreq_snap;
        bus.dma_din_modules = 8'h00;
        bus.dma_select_zx   = 1'b0;
        bus.dma_wrstb       = 1'b0;
        bus.dma_regsel      = 2'd0;
        bus.zx_req          = 1'b0;
        bus.zx_rnw          = 1'b0;
        bus.zx_wdata        = 8'h00;
        repeat (3) @(negedge cpu_clock);
        rst = 1'b0;
        bus.dma_select_zx = 1'b1;

        // reset state
        reg_rd(2'd3, d); chk("rst_cst", d, 8'h10);
        reg_rd(2'd2, d); chk("rst_lad", d, 8'h00);
        chk("rst_req", 32'(bus.mem_req), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_rdata", 32'(bus.zx_rdata), 0);

        // two ZX writes
        reg_wr(2'd0, 8'h01); reg_wr(2'd1, 8'h23); reg_wr(2'd2, 8'h45);
        reg_rd(2'd0, d); chk("had_rb", d, 8'h01);
        reg_wr(2'd3, 8'h80);
        expect_x(1'b0, 21'h012345, 8'hAA, 8'h00);
        expect_x(1'b0, 21'h012346, 8'hBB, 8'h00);
        zx_write(8'hAA);
        zx_write(8'hBB);
        wait_done("wr2");
        reg_rd(2'd2, d); chk("lad_after_wr2", d, 8'h47);

        // FIFO overflow with ack held off
        tb_hold = 1'b1;
        expect_x(1'b0, 21'h012347, 8'h10, 8'h00);
        for (int i = 0; i < 6; i++) zx_write(8'(8'h10 + i));
        reg_rd(2'd3, d); chk("ovf_cst", d, 8'hE8);
        reg_wr(2'd3, 8'hC0);
        reg_rd(2'd3, d); chk("flush_cst", d, 8'hB0);
        tb_hold = 1'b0;
        wait_done("ovf");
        reg_rd(2'd2, d); chk("lad_after_ovf", d, 8'h48);

        // 21-bit address wrap
        reg_wr(2'd3, 8'h00);
        reg_wr(2'd0, 8'h1F); reg_wr(2'd1, 8'hFF); reg_wr(2'd2, 8'hFF);
        expect_x(1'b0, 21'h1FFFFF, 8'h77, 8'h00);
        reg_wr(2'd3, 8'h80);
        zx_write(8'h77);
        wait_done("wrap");
`ifdef DMA_ZX_WRAP64K_EN
        reg_rd(2'd0, d); chk("wrap_had", d, 8'h1F);
`else
        reg_rd(2'd0, d); chk("wrap_had", d, 8'h00);
`endif
        reg_rd(2'd1, d); chk("wrap_mad", d, 8'h00);
        reg_rd(2'd2, d); chk("wrap_lad", d, 8'h00);

        // read prefetch path
        reg_wr(2'd3, 8'h00);
        reg_wr(2'd0, 8'h00); reg_wr(2'd1, 8'h01); reg_wr(2'd2, 8'h00);
        expect_x(1'b1, 21'h000100, 8'h00, 8'h5A);
        reg_wr(2'd3, 8'h81);
        wait_done("rd1");
        chk("rdata_5a", 32'(bus.zx_rdata), 32'h5A);
        reg_rd(2'd3, d); chk("rd_cst", d, 8'h91);
        expect_x(1'b1, 21'h000101, 8'h00, 8'h3C);
        zx_read();
        wait_done("rd2");
        chk("rdata_3c", 32'(bus.zx_rdata), 32'h3C);
        tb_hold = 1'b1;
        expect_x(1'b1, 21'h000102, 8'h00, 8'hC3);
        zx_read();
        repeat (3) @(negedge cpu_clock);
        zx_read();
        reg_rd(2'd3, d); chk("rd_ovr_cst", d, 8'hF1);
        chk("rdata_hold", 32'(bus.zx_rdata), 32'h3C);
        tb_hold = 1'b0;
        wait_done("rd3");
        chk("rdata_c3", 32'(bus.zx_rdata), 32'hC3);
        reg_rd(2'd2, d); chk("lad_after_rd", d, 8'h03);

        // en cleared while a delayed write is outstanding
        reg_wr(2'd3, 8'hC0);
        tb_ack_dly = 5;
        expect_x(1'b0, 21'h000103, 8'h99, 8'h00);
        zx_write(8'h99);
        zx_write(8'h9A);
        reg_wr(2'd3, 8'h00);
        wait_done("en_clr");
        chk("hold_cycles", 32'(tb_last_hold), 5);
        tb_ack_dly = 1;
        nreq_snap = tb_nreq;
        repeat (20) @(negedge cpu_clock);
        chk("no_more_req", 32'(tb_nreq), 32'(nreq_snap));
        reg_rd(2'd2, d); chk("lad_after_clr", d, 8'h04);

        // address write ignored while enabled; deselected read returns zero
        reg_wr(2'd3, 8'h80);
        reg_wr(2'd2, 8'h55);
        reg_rd(2'd2, d); chk("lad_locked", d, 8'h04);
        reg_rd(2'd3, d); chk("en_cst", d, 8'h90);
        @(negedge cpu_clock);
        bus.dma_select_zx = 1'b0;
        #1 chk("desel_dout", 32'(bus.dma_dout_zx), 0);
        repeat (10) @(negedge cpu_clock);
        chk("final_nreq", 32'(tb_nreq), 32'(nreq_snap));
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
